dsp_chain_n_int_sop_acc: RTL

//  Parametrised systolic chain of NUM_STAGES integer sum-of-products stages; each stage computes ax*ay+bx*by.

---
 rtl/dsp_chain_n_int_sop_acc_pkg.sv | 27 ++
 rtl/dsp_chain_n_int_sop_acc_if.sv | 34 +++
 rtl/dsp_chain_n_int_sop_acc_sop_stage.sv | 60 ++++++
 rtl/dsp_chain_n_int_sop_acc.sv | 94 +++++++++
 4 files changed

// File: rtl/dsp_chain_n_int_sop_acc_pkg.sv
// Shared types and helpers for the integer sum-of-products chain: width rule,
// operand extension and the per-sample control tag.
package dsp_chain_pkg;

  localparam int EXT_MAX = 128;

  typedef struct packed {
    logic valid;
    logic acc_en;
    logic acc_clear;
  } tag_t;

  function automatic int chain_w(input int x_w, input int y_w, input int n);
    return (n <= 1) ? x_w + y_w + 1 : x_w + y_w + 1 + $clog2(n);
  endfunction

  // Extend the low w bits of v to EXT_MAX bits, sign- or zero-filling above bit w-1.
  function automatic logic [EXT_MAX-1:0] ext(input logic [EXT_MAX-1:0] v, input int w,
                                             input bit sgn);
    logic [EXT_MAX-1:0] hi;
    logic               msb;
    hi  = {EXT_MAX{1'b1}} << w;
    msb = |(v & ({{(EXT_MAX-1){1'b0}}, 1'b1} << (w - 1)));
    return (sgn && msb) ? (v | hi) : (v & ~hi);
  endfunction

endpackage

// File: rtl/dsp_chain_n_int_sop_acc_if.sv
// Operand/result bundle of the SOP chain; master drives samples, slave is the datapath.
interface dsp_chain_n_int_sop_acc_if #(
  parameter int NUM_STAGES = 4,
  parameter int X_W        = 18,
  parameter int Y_W        = 19,
  parameter int ACC_W      = 48
);
  import dsp_chain_pkg::*;

  localparam int CHAIN_W = chain_w(X_W, Y_W, NUM_STAGES);

  logic                      in_valid;
  logic [NUM_STAGES*X_W-1:0] ax;
  logic [NUM_STAGES*X_W-1:0] bx;
  logic [NUM_STAGES*Y_W-1:0] ay;
  logic [NUM_STAGES*Y_W-1:0] by;
  logic                      acc_en;
  logic                      acc_clear;
  logic                      out_valid;
  logic [CHAIN_W-1:0]        chain_result;
  logic                      acc_valid;
  logic [ACC_W-1:0]          acc_result;
  logic                      acc_ovf;

  modport master (
    output in_valid, ax, bx, ay, by, acc_en, acc_clear,
    input  out_valid, chain_result, acc_valid, acc_result, acc_ovf
  );

  modport slave (
    input  in_valid, ax, bx, ay, by, acc_en, acc_clear,
    output out_valid, chain_result, acc_valid, acc_result, acc_ovf
  );
endinterface

// File: rtl/dsp_chain_n_int_sop_acc_sop_stage.sv
// One systolic SOP stage: IDX-deep operand skew, registered ax*ay+bx*by,
// then registered addition onto the incoming partial chain sum.
module dsp_sop_stage
  import dsp_chain_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int X_W     = 18,
  parameter int Y_W     = 19,
  parameter int SIGNED  = 1,
  parameter int CHAIN_W = 40
) (
  input  logic                      clk,
  input  logic [X_W-1:0]            ax,
  input  logic [X_W-1:0]            bx,
  input  logic [Y_W-1:0]            ay,
  input  logic [Y_W-1:0]            by,
  input  logic signed [CHAIN_W-1:0] chain_in,
  output logic signed [CHAIN_W-1:0] chain_out
);
  localparam int OW = 2 * (X_W + Y_W);
  localparam int PW = X_W + Y_W + 2;

  logic [OW-1:0]              opnd;
  logic [OW-1:0]              opnd_d;
  logic signed [X_W:0]        axe, bxe;
  logic signed [Y_W:0]        aye, bye;
  logic signed [PW-1:0]       prod_a, prod_b;
  logic signed [CHAIN_W-1:0]  p_p0;
  logic signed [CHAIN_W-1:0]  c_p1;

  assign opnd = {ax, bx, ay, by};

  if (IDX == 0) begin : g_direct
    assign opnd_d = opnd;
  end else begin : g_skew
    logic [OW-1:0] skew_sr [IDX];
    always_ff @(posedge clk) begin
      skew_sr[0] <= opnd;
      for (int i = 1; i < IDX; i++) skew_sr[i] <= skew_sr[i-1];
    end
    assign opnd_d = skew_sr[IDX-1];
  end

  // One extra bit per operand lets a single signed multiplier serve both modes.
  assign axe = (X_W+1)'(ext(EXT_MAX'(opnd_d[OW-1 -: X_W]),       X_W, SIGNED != 0));
  assign bxe = (X_W+1)'(ext(EXT_MAX'(opnd_d[OW-X_W-1 -: X_W]),   X_W, SIGNED != 0));
  assign aye = (Y_W+1)'(ext(EXT_MAX'(opnd_d[2*Y_W-1 -: Y_W]),    Y_W, SIGNED != 0));
  assign bye = (Y_W+1)'(ext(EXT_MAX'(opnd_d[Y_W-1:0]),           Y_W, SIGNED != 0));

  assign prod_a = axe * aye;
  assign prod_b = bxe * bye;

  // p0: product sum; p1: cascade onto the previous stage's partial sum
  always_ff @(posedge clk) begin
    p_p0 <= CHAIN_W'(prod_a) + CHAIN_W'(prod_b);
    c_p1 <= chain_in + p_p0;
  end

  assign chain_out = c_p1;
endmodule

// File: rtl/dsp_chain_n_int_sop_acc.sv
// Systolic chain of NUM_STAGES SOP stages with a latency-matched tag pipeline,
// registered chain total and an optional wrapping accumulator with sticky overflow.
module dsp_chain_n_int_sop_acc
  import dsp_chain_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int X_W        = 18,
  parameter int Y_W        = 19,
  parameter int SIGNED     = 1,
  parameter int ACC_W      = 48
) (
  input  logic                      clk,
  input  logic                      reset,
  dsp_chain_n_int_sop_acc_if.slave  bus
);
  localparam int CHAIN_W = chain_w(X_W, Y_W, NUM_STAGES);

  logic signed [CHAIN_W-1:0] chain [NUM_STAGES+1];
  tag_t                      tag_q [NUM_STAGES+1];
  tag_t                      out_tag;
  logic signed [CHAIN_W-1:0] chain_q;
  logic                      acc_vld;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      ovf_q;
  logic [ACC_W-1:0]          t_ext;
  logic [ACC_W:0]            sum_full;
  logic [ACC_W-1:0]          acc_sum;
  logic                      add_ovf;

  assign chain[0] = '0;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    dsp_sop_stage #(
      .IDX(k), .X_W(X_W), .Y_W(Y_W), .SIGNED(SIGNED), .CHAIN_W(CHAIN_W)
    ) u_stage (
      .clk       (clk),
      .ax        (bus.ax[k*X_W +: X_W]),
      .bx        (bus.bx[k*X_W +: X_W]),
      .ay        (bus.ay[k*Y_W +: Y_W]),
      .by        (bus.by[k*Y_W +: Y_W]),
      .chain_in  (chain[k]),
      .chain_out (chain[k+1])
    );
  end

  // Tag shift register: entry NUM_STAGES lines up with the last stage's sum
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i <= NUM_STAGES; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: bus.in_valid, acc_en: bus.acc_en, acc_clear: bus.acc_clear};
      for (int i = 1; i <= NUM_STAGES; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign t_ext    = ACC_W'(ext(EXT_MAX'(chain_q), CHAIN_W, SIGNED != 0));
  assign sum_full = {1'b0, acc_q} + {1'b0, t_ext};
  assign acc_sum  = sum_full[ACC_W-1:0];
  assign add_ovf  = (SIGNED != 0)
                  ? ((acc_q[ACC_W-1] == t_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]))
                  : sum_full[ACC_W];

  // Output register stage, then accumulator stage one cycle later
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_tag <= '0;
      chain_q <= '0;
      acc_vld <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      out_tag <= tag_q[NUM_STAGES];
      if (tag_q[NUM_STAGES].valid) chain_q <= chain[NUM_STAGES];
      acc_vld <= out_tag.valid;
      if (out_tag.valid) begin
        if (out_tag.acc_clear) begin
          acc_q <= t_ext;
          ovf_q <= 1'b0;
        end else if (out_tag.acc_en) begin
          acc_q <= acc_sum;
          ovf_q <= ovf_q | add_ovf;
        end else begin
          acc_q <= t_ext;
        end
      end
    end
  end

  assign bus.out_valid    = out_tag.valid;
  assign bus.chain_result = chain_q;
  assign bus.acc_valid    = acc_vld;
  assign bus.acc_result   = acc_q;
  assign bus.acc_ovf      = ovf_q;
endmodule
